main_ram_ctrl: RTL and testbench
================================

Name: main_ram_ctrl

Overview:
Synchronous controller and two-port arbiter in front of the asynchronous main RAM (active-low _cs/_oe/_w, 20-bit address, 8-bit data, ~5 ns read access, write on falling _w). It accepts single-word read/write requests from port A (CPU) and port B (loader/DMA) and grants one port at a time. For each granted request it sequences the RAM strobes with setup, strobe-width and hold phases, then returns read data and a one-cycle ack.

Parameters:
WIDTH, 8, data word width
ADDR_WIDTH, 20, RAM address width
WAIT_CYCLES, 2, clock cycles the _oe/_w strobe is held low; values below 1 behave as 1

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous reset, active-high
a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  ADDR_WIDTH  port A word address
a_wdata  input  WIDTH  port A write data
a_ack  output  1  port A completion pulse, one cycle
a_rdata  output  WIDTH  port A read data, valid with a_ack, held until the next port A read completes
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
_ram_cs  output  1  RAM chip select, active-low
_ram_oe  output  1  RAM output enable, active-low
_ram_w  output  1  RAM write strobe, active-low
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  WIDTH  RAM write data
ram_rdata  input  WIDTH  RAM read data

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: _ram_cs=_ram_oe=_ram_w=1, ram_addr=0, ram_wdata=0, a_ack=b_ack=0, a_rdata=b_rdata=0, state=IDLE, last_grant=B. All outputs are registered.
- IDLE: sample a_req/b_req. If neither is set, stay in IDLE with all strobes high. If exactly one is set, grant it. If both are set, grant the port that is not last_grant (round-robin). Port A therefore wins the first tie after reset. On grant: latch we/addr/wdata into ram_addr/ram_wdata, update last_grant, go to SETUP.
- SETUP (1 cycle): _ram_cs=0, _ram_oe=1, _ram_w=1; address and data stable. Go to STROBE.
- STROBE (WAIT_CYCLES cycles, counter): _ram_cs=0. Read: _ram_oe=0. Write: _ram_w=0, with data already stable since SETUP. For a read, on the final STROBE edge capture ram_rdata into the granted port's rdata register. Go to HOLD.
- HOLD (1 cycle): _ram_oe=_ram_w=1, _ram_cs=0, address and data still held. The granted port's ack=1. Always go to IDLE.
- Latency from request sampled in IDLE to ack high: 2+WAIT_CYCLES cycles (4 at the default).
- Every access includes one IDLE cycle with _ram_cs=1. Back-to-back throughput is one access per 3+WAIT_CYCLES cycles.
- The non-granted port's request is simply held pending, never dropped. Requests changing mid-transaction are ignored, since latched values are used. A port that keeps req high after its ack is treated as a new request in the next IDLE.
- a_ack and b_ack are never high in the same cycle. ack is never high outside HOLD.
- Reset mid-transaction: at the reset edge all strobes go high and state returns to IDLE. No ack is issued, rdata is cleared, and the aborted request is not retried by the controller.

Optional Feature:
MAIN_RAM_CTRL_FIXED_PRIO_EN
- Defined: fixed priority, port A always wins a tie. last_grant is still tracked but ignored, so B can starve under continuous A requests.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then A write addr 0x00010 data 0xA5 -> _ram_cs low for 4 cycles, _ram_w low exactly 2 cycles starting 1 cycle after _cs falls, a_ack pulses at cycle 4, RAM[0x10]=0xA5.
- A read addr 0x00010 after the above -> _ram_oe low 2 cycles, a_ack at cycle 4 with a_rdata=0xA5, b_ack stays 0, a_rdata holds 0xA5 afterwards.
- A and B both request in the same cycle after reset (A write 0x20=0x11, B write 0x21=0x22) -> A served first, B acked 5 cycles after a_ack, both locations written. Repeat the tie -> B served first.
- Both requests held high continuously for 20 accesses -> grants alternate A,B,A,B. With MAIN_RAM_CTRL_FIXED_PRIO_EN defined -> all 20 grants go to A, b_ack never asserts.
- Assert reset during STROBE of a B write -> strobes high after that edge, no b_ack, state IDLE, next A read is served normally.
- WAIT_CYCLES=1 and WAIT_CYCLES=0 builds, single read -> strobe 1 cycle, ack 3 cycles after request, data correct.

Source files
------------

// File: rtl/main_ram_ctrl_if.sv
// main_ram_ctrl_if: bundles the two client request ports (A = CPU, B = loader/DMA)
// and the asynchronous RAM pin bus that sit around main_ram_ctrl.
//   a_*/b_* : req/we/addr/wdata from the client, ack/rdata back to it
//   _ram_*  : active-low chip select, output enable and write strobe
//   ram_addr/ram_wdata to the RAM, ram_rdata from the RAM
// Modports:
//   slave  - the controller (receives requests, drives the RAM pins)
//   master - the environment (clients plus the RAM device)
interface main_ram_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 20
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [WIDTH-1:0]      a_wdata;
    logic                  a_ack;
    logic [WIDTH-1:0]      a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WIDTH-1:0]      b_wdata;
    logic                  b_ack;
    logic [WIDTH-1:0]      b_rdata;

    logic                  _ram_cs;
    logic                  _ram_oe;
    logic                  _ram_w;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]      ram_wdata;
    logic [WIDTH-1:0]      ram_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output _ram_cs, _ram_oe, _ram_w, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  _ram_cs, _ram_oe, _ram_w, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/main_ram_ctrl.sv
// main_ram_ctrl: two-port arbiter and strobe sequencer for the asynchronous main RAM.
// One single-word access at a time: IDLE (grant) -> SETUP (cs low, address/data
// settle) -> STROBE (oe or w low for WAIT_CYCLES clocks) -> HOLD (strobes high,
// cs low, one-cycle ack to the granted port) -> IDLE.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - main_ram_ctrl_if.slave: port A/B request/ack buses and RAM pins
// All outputs are registered.
// Build option:
//   MAIN_RAM_CTRL_FIXED_PRIO_EN - when defined, port A always wins a tie
//   (B can starve); otherwise ties alternate round-robin.
module main_ram_ctrl #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    main_ram_ctrl_if.slave   bus
);
    // Strobe widths below one clock are not meaningful; clamp to 1.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;     // latched direction of the current access
    logic             gnt_b;    // 1 = current access belongs to port B
    logic             last_b;   // 1 = port B was granted most recently
    logic             pick_b;

    // Grant decision for the IDLE cycle; only meaningful when a request is present.
`ifdef MAIN_RAM_CTRL_FIXED_PRIO_EN
    always_comb pick_b = bus.b_req && !bus.a_req;
`else
    always_comb pick_b = bus.b_req && (!bus.a_req || !last_b);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            gnt_b         <= 1'b0;
            last_b        <= 1'b1;   // so A wins the first tie after reset
            bus._ram_cs   <= 1'b1;
            bus._ram_oe   <= 1'b1;
            bus._ram_w    <= 1'b1;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
        end else begin
            bus.a_ack <= 1'b0;
            bus.b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    bus._ram_cs <= 1'b1;
                    bus._ram_oe <= 1'b1;
                    bus._ram_w  <= 1'b1;
                    if (bus.a_req || bus.b_req) begin
                        gnt_b         <= pick_b;
                        last_b        <= pick_b;
                        we_q          <= pick_b ? bus.b_we    : bus.a_we;
                        bus.ram_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
                        bus.ram_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
                        bus._ram_cs   <= 1'b0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    cnt         <= CNT_LOAD;
                    bus._ram_oe <= we_q;
                    bus._ram_w  <= !we_q;
                    state       <= STROBE;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        // oe is still low during this cycle, so ram_rdata is valid here.
                        if (!we_q) begin
                            if (gnt_b) bus.b_rdata <= bus.ram_rdata;
                            else       bus.a_rdata <= bus.ram_rdata;
                        end
                        bus._ram_oe <= 1'b1;
                        bus._ram_w  <= 1'b1;
                        bus.a_ack   <= !gnt_b;
                        bus.b_ack   <= gnt_b;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    bus._ram_cs <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    bus._ram_cs <= 1'b1;
                    bus._ram_oe <= 1'b1;
                    bus._ram_w  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_main_ram_ctrl.sv
// tb_main_ram_ctrl: directed bench for main_ram_ctrl with a behavioural async RAM.
// Single-port accesses come from a vector table; ties, continuous contention and
// reset mid-access are hand-written sequences.
module tb_main_ram_ctrl;
    localparam int WAIT_CYCLES = 2;
    localparam int WE  = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int LAT = 2 + WE;   // request-to-ack, counted in clock edges
    localparam int GAP = 3 + WE;   // back-to-back ack spacing

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    main_ram_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(20)) bus();

    main_ram_ctrl #(.WIDTH(8), .ADDR_WIDTH(20), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAM: combinational read while cs/oe low, write on falling _w.
    logic [7:0] mem [0:1023];
    assign bus.ram_rdata = (!bus._ram_cs && !bus._ram_oe) ? mem[bus.ram_addr[9:0]] : 8'h00;
    always @(negedge bus._ram_w)
        if (!bus._ram_cs) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;

    // Pin monitor
    int cs_tot = 0, oe_tot = 0, w_tot = 0, a_tot = 0, b_tot = 0, ack_viol = 0;
    int cs_run = 0, strobe_pos = 0;
    logic prev_strobe = 1'b0;
    logic [19:0] strobe_addr = '0;
    always @(negedge clk) begin : mon
        int   run_n;
        logic strobe;
        run_n  = bus._ram_cs ? 0 : cs_run + 1;
        strobe = !bus._ram_oe || !bus._ram_w;
        cs_run <= run_n;
        if (!bus._ram_cs) cs_tot <= cs_tot + 1;
        if (!bus._ram_oe) oe_tot <= oe_tot + 1;
        if (!bus._ram_w)  w_tot  <= w_tot + 1;
        if (strobe && !prev_strobe) begin
            strobe_pos  <= run_n;
            strobe_addr <= bus.ram_addr;
        end
        prev_strobe <= strobe;
        if (bus.a_ack) a_tot <= a_tot + 1;
        if (bus.b_ack) b_tot <= b_tot + 1;
        if ((bus.a_ack && bus.b_ack) ||
            ((bus.a_ack || bus.b_ack) && (bus._ram_cs || !bus._ram_oe || !bus._ram_w)))
            ack_viol <= ack_viol + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One access on one port; returns edges-to-ack and the returned rdata.
    task automatic do_txn(input bit pb, input bit we, input logic [19:0] ad,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd);
        bit done;
        done = 1'b0;
        lat  = 0;
        rd   = '0;
        if (pb) begin
            bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd; bus.b_req = 1'b1;
        end else begin
            bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd; bus.a_req = 1'b1;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pb ? bus.b_ack : bus.a_ack) begin
                done = 1'b1;
                rd   = pb ? bus.b_rdata : bus.a_rdata;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        if (!done) check("txn_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Both ports request in the same cycle; returns the cycle of each ack.
    task automatic tie(input logic [19:0] aa, input logic [7:0] ad,
                       input logic [19:0] ba, input logic [7:0] bd,
                       output int a_at, output int b_at);
        a_at = 0;
        b_at = 0;
        bus.a_we = 1'b1; bus.a_addr = aa; bus.a_wdata = ad; bus.a_req = 1'b1;
        bus.b_we = 1'b1; bus.b_addr = ba; bus.b_wdata = bd; bus.b_req = 1'b1;
        for (int c = 1; c <= 60 && (a_at == 0 || b_at == 0); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.a_ack) begin a_at = c; bus.a_req = 1'b0; end
            if (bus.b_ack) begin b_at = c; bus.b_req = 1'b0; end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        if (a_at == 0 || b_at == 0) check("tie_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_a_rdata", {24'd0, bus.a_rdata}, 32'd0);
        check("reset_b_rdata", {24'd0, bus.b_rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          pb;
        bit          we;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, s_cs, s_oe, s_w, s_a, s_b;
        int a_at, b_at, n, a_n, b_n, sw, gap_bad, last_c;
        logic [7:0] rd;
        bit prev_b;

        vecs[0] = '{1'b0, 1'b1, 20'h00010, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 20'h002AB, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 20'h002AB, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 20'h002AB, 8'h00, 8'h5A};
        vecs[5] = '{1'b1, 1'b1, 20'hFFFFF, 8'hC3, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 20'h00000, 8'h3C, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 20'h00000, 8'h00, 8'h3C};
        vecs[8] = '{1'b0, 1'b0, 20'hFFFFF, 8'h00, 8'hC3};

        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs",    {31'd0, bus._ram_cs}, 32'd1);
        check("rst_oe",    {31'd0, bus._ram_oe}, 32'd1);
        check("rst_w",     {31'd0, bus._ram_w},  32'd1);
        check("rst_addr",  {12'd0, bus.ram_addr}, 32'd0);
        check("rst_wdata", {24'd0, bus.ram_wdata}, 32'd0);
        check("rst_acks",  {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
        check("rst_rdata", {16'd0, bus.a_rdata, bus.b_rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single-port accesses
        foreach (vecs[k]) begin
            s_cs = cs_tot; s_oe = oe_tot; s_w = w_tot; s_a = a_tot; s_b = b_tot;
            do_txn(vecs[k].pb, vecs[k].we, vecs[k].addr, vecs[k].wdata, lat, rd);
            check("latency",    lat, LAT);
            check("cs_cycles",  cs_tot - s_cs, LAT);
            check("strobe_len", vecs[k].we ? w_tot - s_w : oe_tot - s_oe, WE);
            check("other_strb", vecs[k].we ? oe_tot - s_oe : w_tot - s_w, 0);
            check("strobe_pos", strobe_pos, 2);
            check("ram_addr",   {12'd0, strobe_addr}, {12'd0, vecs[k].addr});
            check("other_ack",  vecs[k].pb ? a_tot - s_a : b_tot - s_b, 0);
            if (vecs[k].we) check("mem_write", {24'd0, mem[vecs[k].addr[9:0]]}, {24'd0, vecs[k].wdata});
            else            check("rdata",     {24'd0, rd}, {24'd0, vecs[k].exp_rd});
        end

        // a_rdata must hold across B traffic
        do_txn(1'b1, 1'b0, 20'h00010, 8'h00, lat, rd);
        check("b_rdata", {24'd0, rd}, 32'hA5);
        check("a_rdata_hold", {24'd0, bus.a_rdata}, 32'hC3);

        // First tie after reset: A wins, B follows one access period later
        do_reset();
        tie(20'h00020, 8'h11, 20'h00021, 8'h22, a_at, b_at);
        check("tie1_a_first", a_at, LAT);
        check("tie1_b_gap",   b_at - a_at, GAP);
        check("tie1_mem_a",   {24'd0, mem[10'h020]}, 32'h11);
        check("tie1_mem_b",   {24'd0, mem[10'h021]}, 32'h22);

        // After a lone A access, the next tie goes to B under round-robin
        do_txn(1'b0, 1'b1, 20'h00022, 8'h33, lat, rd);
        tie(20'h00023, 8'h44, 20'h00024, 8'h55, a_at, b_at);
`ifdef MAIN_RAM_CTRL_FIXED_PRIO_EN
        check("tie2_a_first", a_at, LAT);
        check("tie2_b_gap",   b_at - a_at, GAP);
`else
        check("tie2_b_first", b_at, LAT);
        check("tie2_a_gap",   a_at - b_at, GAP);
`endif
        check("tie2_mem_a", {24'd0, mem[10'h023]}, 32'h44);
        check("tie2_mem_b", {24'd0, mem[10'h024]}, 32'h55);

        // Continuous contention for 20 accesses
        bus.a_we = 1'b0; bus.a_addr = 20'h00020; bus.a_req = 1'b1;
        bus.b_we = 1'b0; bus.b_addr = 20'h00021; bus.b_req = 1'b1;
        n = 0; a_n = 0; b_n = 0; sw = 0; gap_bad = 0; last_c = 0; prev_b = 1'b0;
        for (int c = 1; c <= 400 && n < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) begin
                if (n > 0 && bus.b_ack != prev_b) sw++;
                if (n > 0 && c - last_c != GAP) gap_bad++;
                if (bus.b_ack) b_n++; else a_n++;
                prev_b = bus.b_ack;
                last_c = c;
                n++;
                if (n == 20) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        check("stream_count", n, 20);
        check("stream_gap",   gap_bad, 0);
        check("stream_a_rd",  {24'd0, bus.a_rdata}, 32'h11);
`ifdef MAIN_RAM_CTRL_FIXED_PRIO_EN
        check("stream_a_n", a_n, 20);
        check("stream_b_n", b_n, 0);
`else
        check("stream_a_n",  a_n, 10);
        check("stream_b_n",  b_n, 10);
        check("stream_alt",  sw, 19);
        check("stream_b_rd", {24'd0, bus.b_rdata}, 32'h22);
`endif
        repeat (3) @(negedge clk);

        // Reset during STROBE of a B write
        bus.b_we = 1'b1; bus.b_addr = 20'h00040; bus.b_wdata = 8'h77; bus.b_req = 1'b1;
        @(posedge clk);   // grant
        @(posedge clk);   // SETUP -> STROBE
        @(negedge clk);
        check("mid_w_low", {31'd0, bus._ram_w}, 32'd0);
        s_b = b_tot;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_strobes", {29'd0, bus._ram_cs, bus._ram_oe, bus._ram_w}, 32'h7);
        check("mid_b_ack",   {31'd0, bus.b_ack}, 32'd0);
        check("mid_b_rdata", {24'd0, bus.b_rdata}, 32'd0);
        bus.b_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_b_ack", b_tot - s_b, 0);
        check("mid_idle_cs",  {31'd0, bus._ram_cs}, 32'd1);
        do_txn(1'b0, 1'b0, 20'h00010, 8'h00, lat, rd);
        check("post_rst_lat", lat, LAT);
        check("post_rst_rd",  {24'd0, rd}, 32'hA5);

        check("ack_protocol", ack_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
